// File: rtl/instr_mem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loader_if
// Description : Byte-stream handshake and instruction-memory write bus.
// Revision    : 1.0
// ============================================================================
interface instr_mem_loader_if #(
    parameter int AddressWidth = 10
);
    logic                    byte_valid;
    logic [7:0]              byte_data;
    logic                    byte_ready;
    logic                    w_en;
    logic [AddressWidth-1:0] w_addr;
    logic [31:0]             w_data;

    // master: byte producer / memory observer; slave: the loader
    modport master (
        output byte_valid, byte_data,
        input  byte_ready, w_en, w_addr, w_data
    );
    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, w_en, w_addr, w_data
    );
endinterface
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loader
// Description : Packs a little-endian byte stream into 32-bit words, writes
//               them into instruction memory and holds the core in reset.
// Revision    : 1.0
// ============================================================================
module instr_mem_loader #(
    parameter int AddressWidth = 10
) (
    input  wire logic                    clk_i,
    input  wire logic                    rst_ni,
    input  wire logic                    start_i,
    input  wire logic                    abort_i,
    input  wire logic [AddressWidth-2:0] num_words_i,
    instr_mem_loader_if.slave            mem_bus,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         cpu_rst_no
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [AddressWidth-2:0] C_DEPTH = {1'b1, {(AddressWidth-2){1'b0}}};

    state_e                  state_q;
    logic [1:0]              byte_idx_q;
    logic [23:0]             word_q;
    logic [AddressWidth-3:0] word_addr_q;
    logic [AddressWidth-2:0] words_left_q;
    logic                    byte_ready_q;
    logic                    w_en_q;
    logic [AddressWidth-1:0] w_addr_q;
    logic [31:0]             w_data_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    cpu_rst_n_q;

    // Saturating the count keeps the word address from wrapping within a load
    logic [AddressWidth-2:0] w_start_count;
    assign w_start_count = (num_words_i > C_DEPTH) ? C_DEPTH : num_words_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            byte_idx_q   <= '0;
            word_q       <= '0;
            word_addr_q  <= '0;
            words_left_q <= '0;
            byte_ready_q <= 1'b0;
            w_en_q       <= 1'b0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cpu_rst_n_q  <= 1'b0;
        end else begin
            w_en_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        words_left_q <= w_start_count;
                        word_addr_q  <= '0;
                        byte_idx_q   <= '0;
                        if (w_start_count == '0) begin
                            state_q      <= S_DONE;
                            byte_ready_q <= 1'b0;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            cpu_rst_n_q  <= 1'b1;
                        end else begin
                            state_q      <= S_LOAD;
                            byte_ready_q <= 1'b1;
                            busy_q       <= 1'b1;
                            done_q       <= 1'b0;
                            cpu_rst_n_q  <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    if (abort_i) begin
                        state_q      <= S_IDLE;
                        byte_ready_q <= 1'b0;
                        busy_q       <= 1'b0;
                        byte_idx_q   <= '0;
                    end else if (mem_bus.byte_valid && byte_ready_q) begin
                        case (byte_idx_q)
                            2'd0: word_q[7:0]   <= mem_bus.byte_data;
                            2'd1: word_q[15:8]  <= mem_bus.byte_data;
                            2'd2: word_q[23:16] <= mem_bus.byte_data;
                            default: begin
                                // Fourth byte goes straight into the write word
                                state_q      <= S_WRITE;
                                byte_ready_q <= 1'b0;
                                w_en_q       <= 1'b1;
                                w_addr_q     <= {word_addr_q, 2'b00};
                                w_data_q     <= {mem_bus.byte_data, word_q};
                            end
                        endcase
                        byte_idx_q <= byte_idx_q + 2'd1;
                    end
                end
                S_WRITE: begin
                    if (abort_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        word_addr_q  <= word_addr_q + (AddressWidth-2)'(1);
                        words_left_q <= words_left_q - (AddressWidth-1)'(1);
                        if (words_left_q == (AddressWidth-1)'(1)) begin
                            state_q     <= S_DONE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            cpu_rst_n_q <= 1'b1;
                        end else begin
                            state_q      <= S_LOAD;
                            byte_ready_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_bus.byte_ready = byte_ready_q;
    assign mem_bus.w_en       = w_en_q;
    assign mem_bus.w_addr     = w_addr_q;
    assign mem_bus.w_data     = w_data_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign cpu_rst_no         = cpu_rst_n_q;
endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_mem_loader
// Description : Self-checking bench for instr_mem_loader (4-word memory).
// Revision    : 1.0
// ============================================================================
module tb_instr_mem_loader;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << (AW - 2);

    logic          clk_i       = 1'b0;
    logic          rst_ni      = 1'b0;
    logic          start_i     = 1'b0;
    logic          abort_i     = 1'b0;
    logic [AW-2:0] num_words_i = '0;
    logic          busy_o;
    logic          done_o;
    logic          cpu_rst_no;

    instr_mem_loader_if #(.AddressWidth(AW)) bus_if ();

    instr_mem_loader #(.AddressWidth(AW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .num_words_i (num_words_i),
        .mem_bus     (bus_if),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .cpu_rst_no  (cpu_rst_no)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Observed memory writes and stream activity, sampled mid-cycle
    int          wr_addr_q[$];
    int unsigned wr_data_q[$];
    int          ready_during_write = 0;
    int          ready_cycles       = 0;
    int          accepted           = 0;

    always @(negedge clk_i) begin
        if (bus_if.w_en) begin
            wr_addr_q.push_back(int'(bus_if.w_addr));
            wr_data_q.push_back(bus_if.w_data);
            if (bus_if.byte_ready) ready_during_write++;
        end
        if (bus_if.byte_ready) ready_cycles++;
        if (bus_if.byte_valid && bus_if.byte_ready) accepted++;
    end

    function automatic int unsigned pack_word(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2, input logic [7:0] b3);
        return int'(b0) + (int'(b1) * 256) + (int'(b2) * 65536) + (int'(b3) * 16777216);
    endfunction

    task automatic do_start(input int n);
        start_i     = 1'b1;
        num_words_i = (AW-1)'(n);
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        int k  = 0;
        bus_if.byte_valid = 1'b0;
        repeat (gap) begin @(posedge clk_i); #1; end
        bus_if.byte_valid = 1'b1;
        bus_if.byte_data  = b;
        while (!ok && k < 100) begin
            @(negedge clk_i);
            ok = bus_if.byte_ready;
            @(posedge clk_i); #1;
            k++;
        end
        bus_if.byte_valid = 1'b0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL send_byte timeout: byte_ready stayed 0, required 1");
        end
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        @(negedge clk_i);
        while (!done_o && k < 200) begin @(negedge clk_i); k++; end
        n_cmp++;
        if (done_o !== 1'b1) begin
            n_bad++;
            $display("FAIL %s done: got %0b required 1", tag, done_o);
        end
        n_cmp++;
        if (cpu_rst_no !== 1'b1) begin
            n_bad++;
            $display("FAIL %s cpu_rst_no: got %0b required 1", tag, cpu_rst_no);
        end
        @(posedge clk_i); #1;
    endtask

    // Full load of n words with the given byte image; writes compared to the model
    task automatic test_load(input string tag, input int n, input logic [7:0] bq[$], input int maxgap);
        int eff    = (n > DEPTH) ? DEPTH : n;
        int base_w = wr_addr_q.size();
        int base_a = accepted;
        int base_r = ready_during_write;
        do_start(n);
        foreach (bq[i]) send_byte(bq[i], $urandom_range(0, maxgap));
        wait_done(tag);
        n_cmp++;
        if (wr_addr_q.size() - base_w !== eff) begin
            n_bad++;
            $display("FAIL %s write count: got %0d required %0d", tag, wr_addr_q.size() - base_w, eff);
        end
        for (int i = 0; i < eff && base_w + i < wr_addr_q.size(); i++) begin
            int unsigned exp_d = pack_word(bq[4*i], bq[4*i+1], bq[4*i+2], bq[4*i+3]);
            n_cmp++;
            if (wr_addr_q[base_w+i] !== 4 * i) begin
                n_bad++;
                $display("FAIL %s addr[%0d]: got 0x%0h required 0x%0h", tag, i, wr_addr_q[base_w+i], 4 * i);
            end
            n_cmp++;
            if (wr_data_q[base_w+i] !== exp_d) begin
                n_bad++;
                $display("FAIL %s data[%0d]: got 0x%08h required 0x%08h", tag, i, wr_data_q[base_w+i], exp_d);
            end
        end
        n_cmp++;
        if (accepted - base_a !== 4 * eff) begin
            n_bad++;
            $display("FAIL %s accepted bytes: got %0d required %0d", tag, accepted - base_a, 4 * eff);
        end
        n_cmp++;
        if (ready_during_write - base_r !== 0) begin
            n_bad++;
            $display("FAIL %s ready in WRITE: got %0d cycles required 0", tag, ready_during_write - base_r);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        n_cmp++;
        if ({bus_if.byte_ready, bus_if.w_en, busy_o, done_o, cpu_rst_no} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset flags: got %05b required 00000",
                     {bus_if.byte_ready, bus_if.w_en, busy_o, done_o, cpu_rst_no});
        end
        n_cmp++;
        if (bus_if.w_addr !== '0 || bus_if.w_data !== 32'h0) begin
            n_bad++;
            $display("FAIL reset bus: got addr 0x%0h data 0x%08h required 0", bus_if.w_addr, bus_if.w_data);
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_zero_count();
        int base_w = wr_addr_q.size();
        int base_r = ready_cycles;
        do_start(0);
        @(negedge clk_i);
        n_cmp++;
        if (done_o !== 1'b1 || cpu_rst_no !== 1'b1 || busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL zero done: got done %0b cpu_rst_n %0b busy %0b required 1 1 0", done_o, cpu_rst_no, busy_o);
        end
        repeat (4) @(negedge clk_i);
        n_cmp++;
        if (wr_addr_q.size() != base_w || ready_cycles != base_r) begin
            n_bad++;
            $display("FAIL zero activity: got %0d writes %0d ready cycles required 0 0",
                     wr_addr_q.size() - base_w, ready_cycles - base_r);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_single_word();
        do_start(1);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        @(negedge clk_i);
        n_cmp++;
        if (bus_if.w_en !== 1'b1 || bus_if.byte_ready !== 1'b0 || done_o !== 1'b0) begin
            n_bad++;
            $display("FAIL single strobe: got w_en %0b ready %0b done %0b required 1 0 0",
                     bus_if.w_en, bus_if.byte_ready, done_o);
        end
        n_cmp++;
        if (bus_if.w_addr !== 4'h0 || bus_if.w_data !== 32'h0000_0013) begin
            n_bad++;
            $display("FAIL single write: got addr 0x%0h data 0x%08h required 0x0 0x00000013",
                     bus_if.w_addr, bus_if.w_data);
        end
        @(negedge clk_i);
        n_cmp++;
        if (done_o !== 1'b1 || cpu_rst_no !== 1'b1 || bus_if.w_en !== 1'b0) begin
            n_bad++;
            $display("FAIL single done: got done %0b cpu_rst_n %0b w_en %0b required 1 1 0",
                     done_o, cpu_rst_no, bus_if.w_en);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_three_words();
        logic [7:0] bq[$] = '{8'h93, 8'h00, 8'h80, 8'h00, 8'h13, 8'h01, 8'h40, 8'h00,
                              8'hB3, 8'hE1, 8'h20, 8'h00};
        test_load("three", 3, bq, 3);
    endtask

    task automatic test_saturation();
        logic [7:0] bq[$];
        int base_w = wr_addr_q.size();
        int base_a = accepted;
        for (int i = 0; i < 28; i++) bq.push_back(8'($urandom));
        do_start(7);
        for (int i = 0; i < 16; i++) send_byte(bq[i], $urandom_range(0, 1));
        for (int i = 16; i < 28; i++) begin
            bus_if.byte_valid = 1'b1;
            bus_if.byte_data  = bq[i];
            @(posedge clk_i); #1;
        end
        bus_if.byte_valid = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (done_o !== 1'b1 || accepted - base_a !== 16) begin
            n_bad++;
            $display("FAIL sat end: got done %0b accepted %0d required 1 16", done_o, accepted - base_a);
        end
        n_cmp++;
        if (wr_addr_q.size() - base_w !== DEPTH) begin
            n_bad++;
            $display("FAIL sat count: got %0d required %0d", wr_addr_q.size() - base_w, DEPTH);
        end
        for (int i = 0; i < DEPTH && base_w + i < wr_addr_q.size(); i++) begin
            int unsigned exp_d = pack_word(bq[4*i], bq[4*i+1], bq[4*i+2], bq[4*i+3]);
            n_cmp++;
            if (wr_addr_q[base_w+i] !== 4 * i || wr_data_q[base_w+i] !== exp_d) begin
                n_bad++;
                $display("FAIL sat write[%0d]: got 0x%0h/0x%08h required 0x%0h/0x%08h",
                         i, wr_addr_q[base_w+i], wr_data_q[base_w+i], 4 * i, exp_d);
            end
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_abort();
        logic [7:0] bq[$];
        int base_w = wr_addr_q.size();
        do_start(2);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
        abort_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        repeat (3) @(negedge clk_i);
        n_cmp++;
        if ({busy_o, done_o, cpu_rst_no, bus_if.byte_ready} !== 4'b0) begin
            n_bad++;
            $display("FAIL abort state: got busy %0b done %0b cpu_rst_n %0b ready %0b required 0 0 0 0",
                     busy_o, done_o, cpu_rst_no, bus_if.byte_ready);
        end
        n_cmp++;
        if (wr_addr_q.size() - base_w !== 1) begin
            n_bad++;
            $display("FAIL abort writes: got %0d required 1", wr_addr_q.size() - base_w);
        end
        @(posedge clk_i); #1;
        for (int i = 0; i < 4; i++) bq.push_back(8'($urandom));
        test_load("abort restart", 1, bq, 1);
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] bq[$];
        do_start(2);
        send_byte(8'hA5, 0); send_byte(8'h5A, 1);
        do_start(1);
        @(negedge clk_i);
        n_cmp++;
        if (busy_o !== 1'b1 || bus_if.byte_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL start in LOAD: got busy %0b ready %0b required 1 1", busy_o, bus_if.byte_ready);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        n_cmp++;
        if ({bus_if.byte_ready, bus_if.w_en, busy_o, done_o, cpu_rst_no} !== 5'b0 ||
            bus_if.w_addr !== '0 || bus_if.w_data !== 32'h0) begin
            n_bad++;
            $display("FAIL async reset: got flags %05b addr 0x%0h data 0x%08h required all 0",
                     {bus_if.byte_ready, bus_if.w_en, busy_o, done_o, cpu_rst_no},
                     bus_if.w_addr, bus_if.w_data);
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        for (int i = 0; i < 12; i++) bq.push_back(8'($urandom));
        test_load("post reset", 3, bq, 2);
        bq.delete();
        for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
        test_load("reload", 2, bq, 2);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 5; r++) begin
            logic [7:0] bq[$];
            int n   = $urandom_range(1, 7);
            int eff = (n > DEPTH) ? DEPTH : n;
            for (int i = 0; i < 4 * eff; i++) bq.push_back(8'($urandom));
            test_load("random", n, bq, 2);
        end
    endtask

    initial begin
        bus_if.byte_valid = 1'b0;
        bus_if.byte_data  = 8'h00;
        test_reset();
        test_zero_count();
        test_single_word();
        test_three_words();
        test_saturation();
        test_abort();
        test_reset_mid_load();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Writer side of the instruction memory. Receives a little-endian byte stream over a valid/ready handshake and packs every 4 bytes into a 32-bit instruction word. Issues one-cycle word writes into a writable instruction memory, starting at word 0. Holds the CPU core in reset while the memory image is being loaded and releases it once the last word has been written.

Parameters:
AddressWidth, 10, byte-address width of the instruction memory; depth = 2**(AddressWidth-2) words

Ports:
clk_i  in  1  system clock, rising edge
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  single-cycle pulse; begins a load (sampled only in IDLE or DONE)
abort_i  in  1  cancels an in-progress load
num_words_i  in  AddressWidth-1  number of words to load; sampled when start_i is accepted
byte_valid_i  in  1  byte stream valid
byte_data_i  in  8  byte stream data
byte_ready_o  out  1  byte stream ready
w_en_o  out  1  instruction memory write strobe
w_addr_o  out  AddressWidth  byte address of the write; bits [1:0] are always 00
w_data_o  out  32  instruction word to write
busy_o  out  1  high in LOAD and WRITE
done_o  out  1  high in DONE
cpu_rst_no  out  1  active-low reset to the core; low unless the state is DONE

Behaviour:
- Clock and reset: single clock clk_i. rst_ni is asynchronous and active-low.
- Reset values: state=IDLE, byte_ready_o=0, w_en_o=0, w_addr_o=0, w_data_o=0, busy_o=0, done_o=0, cpu_rst_no=0. Internal byte index=0, word address=0, words_left=0.
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE/DONE with start_i=1:
  - Latch words_left = min(num_words_i, depth) and clear the address and byte index.
  - If the latched count is 0, go to DONE; otherwise go to LOAD.
  - start_i in LOAD or WRITE is ignored.
- LOAD:
  - byte_ready_o=1.
  - A byte is accepted when byte_valid_i and byte_ready_o are both high.
  - Accepted byte k (k=0..3) is stored in the word buffer at bits [8k+7:8k]; byte 0 is the LSB.
  - On the 4th accepted byte, go to WRITE next cycle and reset the byte index to 0.
- WRITE (exactly 1 cycle):
  - byte_ready_o=0, w_en_o=1, w_addr_o = word address, w_data_o = assembled word.
  - Next cycle: word address += 4 and words_left -= 1.
  - If words_left was 1, go to DONE; otherwise go back to LOAD.
- Outputs outside WRITE: w_en_o=0 in every other state. w_addr_o/w_data_o hold their last values; they are only meaningful while w_en_o=1.
- DONE: done_o=1 and cpu_rst_no=1, held until the next accepted start_i.
  - A new start drops cpu_rst_no and done_o in the cycle after start_i.
- Latencies:
  - From the 4th accepted byte to w_en_o is 1 cycle.
  - From the last write to done_o/cpu_rst_no high is 1 cycle.
  - Minimum per word is 5 cycles: 4 LOAD + 1 WRITE.
- abort_i in LOAD or WRITE:
  - Go to IDLE next cycle. A partial word is discarded and no write is issued.
  - In WRITE, abort has priority over the write, so w_en_o stays as already driven this cycle; the address does not advance.
  - cpu_rst_no stays 0 and done_o stays 0.
  - abort_i in IDLE or DONE is ignored.
- Counting and addressing rules:
  - The address counter is AddressWidth bits with the low 2 bits forced to 0.
  - The saturated count guarantees the address never wraps within a load.
  - num_words_i == depth loads the full memory; the last write is at byte address 2**AddressWidth - 4.
- Gaps in the stream: byte_valid_i may drop at any time in LOAD; the FSM waits with no timeout.
- Bytes presented in IDLE, WRITE or DONE are not accepted, because byte_ready_o=0.
- Reset mid-load: return immediately to the reset values. The memory contents already written are left untouched.

Test Plan:
- Single word: start_i with num_words_i=1, bytes 13,00,00,00 sent back-to-back -> one w_en_o pulse, w_addr_o=0x000, w_data_o=0x00000013. done_o=1 and cpu_rst_no=1 one cycle later.
- Three words with random valid gaps: bytes for 0x00800093, 0x00400113, 0x0020E1B3 -> writes at 0x000, 0x004, 0x008 with exact data. byte_ready_o=0 during each WRITE cycle, and exactly 3 strobes.
- Zero count: num_words_i=0 -> DONE the next cycle, no w_en_o, byte_ready_o never high.
- Saturation (AddressWidth=4, depth 4): num_words_i=7 with 28 bytes offered -> exactly 4 writes at 0x0, 0x4, 0x8, 0xC, then DONE. The remaining 12 bytes are not accepted.
- Abort after 2 bytes of word 1 in a 2-word load -> IDLE, no second write, cpu_rst_no=0. A restart with num_words_i=1 then writes at address 0x000 with freshly assembled data.
- rst_ni asserted mid-LOAD (asynchronously, between clock edges) -> all outputs go to their reset values immediately. start_i issued during LOAD is ignored, and reload from DONE works.
